trig_conditioner: RTL and testbench

//   Front end of the RF pulse-sequence path. Conditions the raw external trigger pin into one

---
 rtl/trig_conditioner.sv | 137 +++++++++++++
 tb/tb_trig_conditioner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_conditioner.sv
// ============================================================================
// Module   : trig_conditioner
// Brief    : Sync, glitch-filter, edge-detect and hold off an external trigger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_conditioner #(
    parameter int FILTER_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             seq_busy,
    output logic             trig,
    output logic             armed,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] missed_count
);

    localparam int FC_W = $clog2(FILTER_CYCLES + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [FC_W-1:0] c_FILT_LAST = FC_W'(FILTER_CYCLES - 1);
    localparam logic [HO_W-1:0] c_HOLD_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOW  = 3'd1,
        WAIT_HIGH = 3'd2,
        FIRE      = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_s1;
    logic              r_s2;
    logic              r_f;
    logic              r_f_q;
    logic [FC_W-1:0]   r_fcnt;
    logic [HO_W-1:0]   r_hcnt;
    logic [CNT_W-1:0]  r_trig_count;
    logic [CNT_W-1:0]  r_missed_count;
    logic              w_qe;
    logic              w_inc_trig;
    logic              w_inc_miss;

    // Filtered level must disagree with the synced input for FILTER_CYCLES
    // consecutive cycles before it follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_f    <= 1'b0;
            r_f_q  <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_s1  <= trig_in;
            r_s2  <= r_s1;
            r_f_q <= r_f;
            if (r_s2 != r_f) begin
                if (r_fcnt == c_FILT_LAST) begin
                    r_f    <= ~r_f;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_qe = r_f & ~r_f_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_hcnt         <= '0;
            r_trig_count   <= '0;
            r_missed_count <= '0;
        end else begin
            r_state <= w_next;
            r_hcnt  <= (r_state == HOLDOFF) ? r_hcnt + 1'b1 : '0;
            if (w_inc_trig && (r_trig_count != {CNT_W{1'b1}}))
                r_trig_count <= r_trig_count + 1'b1;
            if (w_inc_miss && (r_missed_count != {CNT_W{1'b1}}))
                r_missed_count <= r_missed_count + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_inc_trig = 1'b0;
        w_inc_miss = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (arm) w_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!r_f) w_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (w_qe) begin
                    if (seq_busy) begin
                        w_inc_miss = 1'b1;
                        w_next     = WAIT_LOW;
                    end else begin
                        w_next = FIRE;
                    end
                end
            end
            FIRE: begin
                w_inc_trig = 1'b1;
                w_next     = HOLDOFF;
            end
            HOLDOFF: begin
                if (w_qe) w_inc_miss = 1'b1;
                if (r_hcnt == c_HOLD_LAST) w_next = WAIT_LOW;
            end
            default: w_next = IDLE;
        endcase
        // Disarm overrides the transition but an issued FIRE still counts.
        if (!arm) w_next = IDLE;
    end

    assign trig         = (r_state == FIRE);
    assign armed        = (r_state == WAIT_HIGH);
    assign trig_count   = r_trig_count;
    assign missed_count = r_missed_count;

endmodule

`default_nettype wire

// File: tb/tb_trig_conditioner.sv
// ============================================================================
// Module   : tb_trig_conditioner
// Brief    : Directed self-checking bench for trig_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trig_conditioner;

    localparam int FILTER_CYCLES  = 4;
    localparam int HOLDOFF_CYCLES = 50;
    localparam int CNT_W          = 2;

    logic             clk;
    logic             rst;
    logic             trig_in;
    logic             arm;
    logic             seq_busy;
    logic             trig;
    logic             armed;
    logic [CNT_W-1:0] trig_count;
    logic [CNT_W-1:0] missed_count;

    int checks;
    int failures;
    int n;

    trig_conditioner #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .arm         (arm),
        .seq_busy    (seq_busy),
        .trig        (trig),
        .armed       (armed),
        .trig_count  (trig_count),
        .missed_count(missed_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance a number of cycles, returning how many trig pulses were seen.
    task automatic run(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (trig === 1'b1) pulses++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        arm      = 1'b0;
        trig_in  = 1'b0;
        seq_busy = 1'b0;
        run(3, n);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        arm      = 1'b0;
        trig_in  = 1'b0;
        seq_busy = 1'b0;
        #1;

        // Reset state
        do_reset();
        check("rst_trig", trig, 0);
        check("rst_armed", armed, 0);
        check("rst_tcnt", trig_count, 0);
        check("rst_mcnt", missed_count, 0);

        // 1: latency, trig high only in the cycle after edge 7
        arm = 1'b1;
        run(3, n);
        check("t1_armed", armed, 1);
        trig_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("t1_trig_edge%0d", k), trig, (k == 7) ? 1 : 0);
        end
        check("t1_tcnt", trig_count, 1);
        check("t1_mcnt", missed_count, 0);
        check("t1_armed_holdoff", armed, 0);

        // 2: 3-cycle glitch is dropped silently
        do_reset();
        arm = 1'b1;
        run(3, n);
        trig_in = 1'b1;
        run(3, n);
        trig_in = 1'b0;
        begin
            int p;
            run(20, p);
            n = n + p;
        end
        check("t2_pulses", n, 0);
        check("t2_tcnt", trig_count, 0);
        check("t2_mcnt", missed_count, 0);
        check("t2_armed", armed, 1);

        // 3: second trigger inside holdoff is missed, third after holdoff fires
        do_reset();
        arm = 1'b1;
        run(3, n);
        trig_in = 1'b1; run(10, n);
        check("t3_first", n, 1);
        trig_in = 1'b0; run(10, n);
        check("t3_low1", n, 0);
        trig_in = 1'b1; run(10, n);
        check("t3_second", n, 0);
        check("t3_mcnt_a", missed_count, 1);
        trig_in = 1'b0; run(60, n);
        check("t3_low2", n, 0);
        check("t3_rearmed", armed, 1);
        trig_in = 1'b1; run(10, n);
        check("t3_third", n, 1);
        check("t3_tcnt", trig_count, 2);
        check("t3_mcnt_b", missed_count, 1);

        // 4: seq_busy rejects the edge, a later edge fires
        do_reset();
        arm = 1'b1;
        run(3, n);
        seq_busy = 1'b1;
        trig_in  = 1'b1; run(10, n);
        check("t4_busy_pulses", n, 0);
        check("t4_busy_mcnt", missed_count, 1);
        check("t4_busy_armed", armed, 0);
        seq_busy = 1'b0;
        trig_in  = 1'b0; run(10, n);
        check("t4_rearmed", armed, 1);
        trig_in = 1'b1; run(10, n);
        check("t4_fire", n, 1);
        check("t4_tcnt", trig_count, 1);
        check("t4_mcnt", missed_count, 1);

        // 5: input already high at arm time must go low before firing
        do_reset();
        trig_in = 1'b1;
        run(10, n);
        arm = 1'b1;
        run(10, n);
        check("t5_high_pulses", n, 0);
        check("t5_high_armed", armed, 0);
        trig_in = 1'b0; run(10, n);
        check("t5_low_pulses", n, 0);
        check("t5_low_armed", armed, 1);
        trig_in = 1'b1; run(10, n);
        check("t5_fire", n, 1);
        check("t5_tcnt", trig_count, 1);

        // 6: trig_count saturates at 3, then reset during holdoff
        do_reset();
        arm = 1'b1;
        run(3, n);
        begin
            int total;
            total = 0;
            for (int j = 0; j < 5; j++) begin
                trig_in = 1'b1; run(10, n); total += n;
                trig_in = 1'b0; run(60, n); total += n;
            end
            check("t6_pulses", total, 5);
        end
        check("t6_tcnt_sat", trig_count, 3);
        check("t6_mcnt", missed_count, 0);
        trig_in = 1'b1;
        run(9, n);
        check("t6_sixth", n, 1);
        check("t6_holdoff_armed", armed, 0);
        rst = 1'b1;
        tick();
        check("t6_rst_trig", trig, 0);
        check("t6_rst_armed", armed, 0);
        check("t6_rst_tcnt", trig_count, 0);
        check("t6_rst_mcnt", missed_count, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
